irq_pending_latch: RTL and testbench
====================================

// Module: irq_pending_latch
// PURPOSE
//   Front-end stage for the 4-to-2 priority encoder. Captures request events on up to
//   four lines into sticky pending bits and applies a per-line mask. Drives the masked
//   pending vector to the encoder's D input. Also resolves the highest-priority line
//   itself and offers it as a grant over a valid/ready handshake, clearing the
//   serviced bit on acceptance.
// PARAMETERS
//   NREQ   4   number of request lines; only 4 is supported, matching the 4x2 encoder
//   IDXW   2   grant index width, equal to clog2(NREQ)
// PORTS
//   clk          in   1     rising-edge clock
//   rst          in   1     synchronous, active-high reset
//   req_in       in   4     request lines, one per source
//   mask         in   4     1 = line masked: it stays pending but is never offered
//   clr_all      in   1     1-cycle pulse: clears all pending/ovf bits and aborts any offer
//   d_out        out  4     registered pending & ~mask; connects to encoder D
//   grant_valid  out  1     a grant is offered
//   grant_idx    out  2     index of the offered line; bit 3 has highest priority
//   grant_ready  in   1     consumer accepts the grant this cycle
//   ovf          out  4     sticky: a new event hit a line that was already pending
// BEHAVIOUR
//   - Reset: pending=0, ovf=0, d_out=0, grant_valid=0, grant_idx=0, state=IDLE.
//   - Set event set[i]: req_in[i]=1 in any cycle (level mode; see CONFIGURATION).
//     A set event makes pending[i]=1 in the next cycle.
//   - d_out = pending & ~mask, registered; updates one cycle after pending/mask change.
//   - Priority: 3 > 2 > 1 > 0, the same order as the encoder.
//     Candidate = highest i with pending[i] & ~mask[i].
//   - FSM IDLE: if any candidate exists, latch grant_idx = candidate, set grant_valid=1
//     next cycle, and go to OFFER. Otherwise stay in IDLE.
//   - FSM OFFER:
//     - grant_valid and grant_idx are held stable until grant_ready=1.
//       Mask changes and higher-priority arrivals do not retract or alter the offer.
//     - On valid&ready: clear pending[grant_idx], drop grant_valid next cycle, go to IDLE.
//       A new offer appears no earlier than 1 cycle later, so there is at least a
//       1-cycle gap between grants.
//   - Latency: req_in high in cycle n -> pending in n+1 -> grant_valid=1 in n+2
//     (when IDLE and unmasked).
//   - Same-cycle set and clear of one line: the set wins, so pending stays 1.
//     ovf is not raised in this case.
//   - ovf[i] is set when set[i]=1, pending[i]=1, and the line is not being cleared by
//     acceptance that cycle. ovf is cleared only by rst or clr_all.
//   - clr_all:
//     - pending, ovf and d_out all read 0 in the next cycle.
//     - If in OFFER, grant_valid=0 next cycle and the FSM goes to IDLE.
//     - A grant_ready arriving in the same cycle is ignored.
//     - Set events in the clr_all cycle are discarded.
//   - rst has priority over clr_all and all other inputs.
//   - A masked line that becomes unmasked while pending is offered normally.
// CONFIGURATION
//   EDGE_DETECT_EN defined:
//     - req_in is registered to req_q (reset 0); set[i] = req_in[i] & ~req_q[i].
//     - A line held high produces exactly one set event.
//     - Latency is unchanged.
//   EDGE_DETECT_EN undefined:
//     - set[i] = req_in[i], level mode.
//     - A line held high re-sets pending every cycle and raises ovf once it is pending.
// TESTING
//   1. rst=1 for 2 cycles -> d_out=0000, grant_valid=0, grant_idx=00, ovf=0000.
//   2. req_in=0001 for 1 cycle, grant_ready=1 -> grant_valid=1 with grant_idx=00 two
//      cycles later; accepted, pending->0000, d_out=0000.
//   3. req_in=1010 for 1 cycle, grant_ready=0 for 3 cycles, then 1 ->
//      grant_idx=11 stable throughout; after acceptance, grant_idx=01 is offered after
//      the 1-cycle gap.
//   4. mask=0100, req_in=0100 -> d_out=0000, no grant.
//      Then mask=0000 -> d_out=0100, grant_idx=10.
//   5. Line 2 pending and offered; pulse req_in=0100 again -> ovf=0100.
//      Then set and accept line 2 in the same cycle -> pending[2] stays 1, no new ovf.
//   6. While in OFFER, pulse clr_all together with grant_ready=1 -> next cycle
//      grant_valid=0, d_out=0000, ovf=0000.
//      Hold req_in=0001 for 5 cycles: with EDGE_DETECT_EN -> one grant and ovf=0000;
//      without it -> ovf[0]=1.

Source files
------------

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: sticky per-line request capture with mask, encoder D feed and priority grant.
// Latency: req_in in cycle n -> pending in n+1 -> d_out and grant_valid in n+2 (idle, unmasked).
// Backpressure: an offered grant is held unchanged until grant_ready; events keep latching meanwhile.
// Build option: define EDGE_DETECT_EN to capture rising edges of req_in instead of levels.
module irq_pending_latch #(
  parameter int NREQ = 4,  // only 4 lines are supported (matches the 4x2 encoder)
  parameter int IDXW = 2   // clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_in,
  input  logic [NREQ-1:0] mask,
  input  logic            clr_all,
  output logic [NREQ-1:0] d_out,
  output logic            grant_valid,
  output logic [IDXW-1:0] grant_idx,
  input  logic            grant_ready,
  output logic [NREQ-1:0] ovf
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IDXW-1:0] idx_nxt;
  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] set;
  logic [NREQ-1:0] clr_vec;
  logic [NREQ-1:0] cand_vec;
  logic [IDXW-1:0] cand_idx;
  logic            cand_any;
  logic            accept;

`ifdef EDGE_DETECT_EN
  logic [NREQ-1:0] req_q;

  // Previous request levels, so a held line yields a single set event.
  always_ff @(posedge clk) begin
    if (rst) req_q <= '0;
    else     req_q <= req_in;
  end

  assign set = req_in & ~req_q;
`else
  assign set = req_in;
`endif

  // clr_all aborts the offer, so a coincident grant_ready is not an acceptance.
  assign accept      = (state == OFFER) && grant_ready && !clr_all;
  assign grant_valid = (state == OFFER);
  assign cand_vec    = pending & ~mask;
  assign cand_any    = |cand_vec;

  // Highest unmasked pending line wins; later iterations override lower indices.
  always_comb begin
    cand_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (cand_vec[i]) cand_idx = IDXW'(i);
    end
  end

  // One-hot clear of the line being serviced this cycle.
  always_comb begin
    clr_vec = '0;
    if (accept) clr_vec[grant_idx] = 1'b1;
  end

  // Next state and latched index: the index only moves when a new offer is made.
  always_comb begin
    state_nxt = state;
    idx_nxt   = grant_idx;
    case (state)
      IDLE: begin
        if (!clr_all && cand_any) begin
          state_nxt = OFFER;
          idx_nxt   = cand_idx;
        end
      end
      OFFER: begin
        if (clr_all || grant_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and offered index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= '0;
    end else begin
      state     <= state_nxt;
      grant_idx <= idx_nxt;
    end
  end

  // Pending, overflow and encoder feed; a set beats a same-cycle acceptance clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      ovf     <= '0;
      d_out   <= '0;
    end else if (clr_all) begin
      pending <= '0;
      ovf     <= '0;
      d_out   <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | set;
      ovf     <= ovf | (set & pending & ~clr_vec);
      d_out   <= pending & ~mask;
    end
  end

endmodule

// File: tb/tb_irq_pending_latch.sv
module tb_irq_pending_latch;

  logic       clk;
  logic       rst;
  logic [3:0] req_in;
  logic [3:0] mask;
  logic       clr_all;
  logic [3:0] d_out;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic       grant_ready;
  logic [3:0] ovf;

  int checks   = 0;
  int failures = 0;

  irq_pending_latch #(.NREQ(4), .IDXW(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_in      (req_in),
    .mask        (mask),
    .clr_all     (clr_all),
    .d_out       (d_out),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_ready (grant_ready),
    .ovf         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] mask;
    logic       clr;
    logic       rdy;
    logic [3:0] exp_d;
    logic       exp_gv;
    logic [1:0] exp_gi;
    logic [3:0] exp_ovf;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] m,
                       input logic c, input logic rdy);
    rst         = r;
    req_in      = rq;
    mask        = m;
    clr_all     = c;
    grant_ready = rdy;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   ngrants;
    logic seen;

    // Each row: inputs for one cycle, then outputs expected just after that edge.
    //           rst   req      mask     clr   rdy  | d_out    gv    gi     ovf
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000};
    vecs[1]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000};
    vecs[2]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000};
    vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 4'b0000};
    vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0, 4'b0000};
    vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000};
    vecs[6]  = '{1'b0, 4'b1010, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000};
    vecs[7]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1010, 1'b1, 2'd3, 4'b0000};
    vecs[8]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1010, 1'b1, 2'd3, 4'b0000};
    vecs[9]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1010, 1'b1, 2'd3, 4'b0000};
    vecs[10] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1010, 1'b1, 2'd3, 4'b0000};
    vecs[11] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1010, 1'b0, 2'd3, 4'b0000};
    vecs[12] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 4'b0000};
    vecs[13] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0010, 1'b0, 2'd1, 4'b0000};
    vecs[14] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 4'b0000};
    vecs[15] = '{1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 4'b0000};
    vecs[16] = '{1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 4'b0000};
    vecs[17] = '{1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 4'b0000};
    vecs[18] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b0000};
    vecs[19] = '{1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b0100};
    vecs[20] = '{1'b0, 4'b1000, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 4'b0100};
    vecs[21] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1100, 1'b0, 2'd2, 4'b0100};
    vecs[22] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 4'b0100};
    vecs[23] = '{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd3, 4'b0000};
    vecs[24] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 4'b0000};

    drive(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);

    for (int k = 0; k < 25; k++) begin
      drive(vecs[k].rst, vecs[k].req, vecs[k].mask, vecs[k].clr, vecs[k].rdy);
      step();
      chk($sformatf("vec%0d d_out", k), {4'b0, d_out}, {4'b0, vecs[k].exp_d});
      chk($sformatf("vec%0d grant_valid", k), {7'b0, grant_valid}, {7'b0, vecs[k].exp_gv});
      chk($sformatf("vec%0d grant_idx", k), {6'b0, grant_idx}, {6'b0, vecs[k].exp_gi});
      chk($sformatf("vec%0d ovf", k), {4'b0, ovf}, {4'b0, vecs[k].exp_ovf});
    end

    // Set and accept line 2 in the same cycle: pending survives, no overflow.
    drive(1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 8 && !seen; t++) begin
      step();
      seen = grant_valid;
    end
    chk("seqA offer_seen", {7'b0, seen}, 8'd1);
    chk("seqA offer_idx", {6'b0, grant_idx}, 8'd2);
    drive(1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1);
    step();
    chk("seqA gap_valid", {7'b0, grant_valid}, 8'd0);
    chk("seqA no_ovf", {4'b0, ovf}, 8'd0);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step();
    chk("seqA reoffer_valid", {7'b0, grant_valid}, 8'd1);
    chk("seqA reoffer_idx", {6'b0, grant_idx}, 8'd2);
    chk("seqA d_out_kept", {4'b0, d_out}, 8'h04);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    step();
    chk("seqA accept_drop", {7'b0, grant_valid}, 8'd0);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step();
    step();
    chk("seqA d_out_clear", {4'b0, d_out}, 8'd0);
    chk("seqA idle_valid", {7'b0, grant_valid}, 8'd0);

    // Hold line 0 high for five cycles with the consumer always ready.
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    step();
    chk("seqB clr_ovf", {4'b0, ovf}, 8'd0);
    ngrants = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, (i < 5) ? 4'b0001 : 4'b0000, 4'b0000, 1'b0, 1'b1);
      step();
      if (grant_valid) ngrants++;
    end
`ifdef EDGE_DETECT_EN
    chk("seqB grants", 8'(ngrants), 8'd1);
    chk("seqB ovf", {4'b0, ovf}, 8'd0);
`else
    chk("seqB grants", 8'(ngrants), 8'd3);
    chk("seqB ovf", {4'b0, ovf}, 8'h01);
`endif
    chk("seqB final_pending", {4'b0, d_out}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
